// File: rtl/banked_ioiq_gen.sv
// Banked in-order issue queue: each bank is a circular FIFO of renamed micro-ops
// with writeback wakeup, head-only issue and single-cycle age-based recall.
module banked_ioiq_gen #(
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AL_SIZE   = 32,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned NUM_WB    = 4,
  parameter int unsigned PAYLOAD_W = 32,
  localparam int unsigned AL_W     = $clog2(AL_SIZE),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ext_stall,
  input  logic [NUM_BANKS-1:0]           enq_valid,
  input  logic [NUM_BANKS*AL_W-1:0]      enq_al_addr,
  input  logic [NUM_BANKS*PREG_W-1:0]    enq_src1,
  input  logic [NUM_BANKS*PREG_W-1:0]    enq_src2,
  input  logic [NUM_BANKS-1:0]           enq_src1_rdy,
  input  logic [NUM_BANKS-1:0]           enq_src2_rdy,
  input  logic [NUM_BANKS*PAYLOAD_W-1:0] enq_payload,
  input  logic                           if_recall,
  input  logic [AL_W-1:0]                new_front,
  input  logic [AL_W-1:0]                back,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]       wb_tag,
  output logic [NUM_BANKS-1:0]           iss_valid,
  input  logic [NUM_BANKS-1:0]           iss_ready,
  output logic [NUM_BANKS*AL_W-1:0]      iss_al_addr,
  output logic [NUM_BANKS*PAYLOAD_W-1:0] iss_payload,
  output logic [NUM_BANKS*CNT_W-1:0]     occupancy,
  output logic                           int_stall
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [AL_W-1:0]      al_addr;
    logic [PREG_W-1:0]    src1;
    logic                 r1;
    logic [PREG_W-1:0]    src2;
    logic                 r2;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t               mem_q   [NUM_BANKS][DEPTH];
  logic [PTR_W-1:0]     head_q  [NUM_BANKS];
  logic [PTR_W-1:0]     tail_q  [NUM_BANKS];
  logic [CNT_W-1:0]     cnt_q   [NUM_BANKS];
  logic [PTR_W-1:0]     head_d  [NUM_BANKS];
  logic [PTR_W-1:0]     tail_d  [NUM_BANKS];
  logic [CNT_W-1:0]     cnt_d   [NUM_BANKS];
  logic [CNT_W-1:0]     surv    [NUM_BANKS];
  logic [DEPTH-1:0]     wake1   [NUM_BANKS];
  logic [DEPTH-1:0]     wake2   [NUM_BANKS];
  entry_t               enq_e   [NUM_BANKS];
  entry_t               head_e  [NUM_BANKS];
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] pop;
  logic [NUM_BANKS-1:0] enq_fire;
  logic [NUM_BANKS-1:0] head_killed;
  logic [AL_W-1:0]      age_nf;

  function automatic logic wb_hit(input logic [PREG_W-1:0]        tag,
                                  input logic [NUM_WB-1:0]        v,
                                  input logic [NUM_WB*PREG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (v[k] && (t[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Age relative to the oldest live op; wraps naturally in AL_W bits.
  function automatic logic [AL_W-1:0] age_of(input logic [AL_W-1:0] a,
                                             input logic [AL_W-1:0] base);
    return a - base;
  endfunction

  // Incoming entries, with same-cycle writeback folded into the ready bits.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      enq_e[b].al_addr = enq_al_addr[b*AL_W +: AL_W];
      enq_e[b].src1    = enq_src1[b*PREG_W +: PREG_W];
      enq_e[b].src2    = enq_src2[b*PREG_W +: PREG_W];
      enq_e[b].payload = enq_payload[b*PAYLOAD_W +: PAYLOAD_W];
      enq_e[b].r1      = enq_src1_rdy[b] | wb_hit(enq_src1[b*PREG_W +: PREG_W], wb_valid, wb_tag);
      enq_e[b].r2      = enq_src2_rdy[b] | wb_hit(enq_src2[b*PREG_W +: PREG_W], wb_valid, wb_tag);
    end
  end

  // Wakeup match for every stored entry.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wake1[b] = '0;
      wake2[b] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        wake1[b][i] = wb_hit(mem_q[b][i].src1, wb_valid, wb_tag);
        wake2[b][i] = wb_hit(mem_q[b][i].src2, wb_valid, wb_tag);
      end
    end
  end

  // Recall survivors and head issue eligibility.
  always_comb begin
    age_nf = age_of(new_front, back);
    for (int b = 0; b < NUM_BANKS; b++) begin
      surv[b]        = '0;
      head_e[b]      = mem_q[b][head_q[b]];
      full[b]        = (cnt_q[b] == CNT_W'(DEPTH));
      head_killed[b] = if_recall && (cnt_q[b] != '0) &&
                       (age_of(head_e[b].al_addr, back) >= age_nf);
      iss_valid[b]   = (cnt_q[b] != '0) && head_e[b].r1 && head_e[b].r2 && !head_killed[b];
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < cnt_q[b]) &&
            (age_of(mem_q[b][PTR_W'(head_q[b] + PTR_W'(i))].al_addr, back) < age_nf)) begin
          surv[b] = surv[b] + CNT_W'(1);
        end
      end
    end
  end

  // Pointer and count next state; recall overrides enqueue.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      pop[b]      = iss_valid[b] & iss_ready[b];
      enq_fire[b] = enq_valid[b] && !full[b] && !ext_stall && !if_recall;
      head_d[b]   = head_q[b] + PTR_W'(pop[b]);
      tail_d[b]   = tail_q[b];
      cnt_d[b]    = cnt_q[b];
      if (if_recall) begin
        tail_d[b] = head_q[b] + PTR_W'(surv[b]);
        cnt_d[b]  = surv[b] - CNT_W'(pop[b]);
      end else begin
        tail_d[b] = tail_q[b] + PTR_W'(enq_fire[b]);
        cnt_d[b]  = cnt_q[b] + CNT_W'(enq_fire[b]) - CNT_W'(pop[b]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        head_q[b] <= '0;
        tail_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        head_q[b] <= head_d[b];
        tail_q[b] <= tail_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
    end
  end

  // Entry storage: write at tail, otherwise accumulate ready bits.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire[b] && (tail_q[b] == PTR_W'(i))) begin
          mem_q[b][i] <= enq_e[b];
        end else begin
          if (wake1[b][i]) mem_q[b][i].r1 <= 1'b1;
          if (wake2[b][i]) mem_q[b][i].r2 <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    iss_al_addr = '0;
    iss_payload = '0;
    occupancy   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      iss_al_addr[b*AL_W +: AL_W]           = head_e[b].al_addr;
      iss_payload[b*PAYLOAD_W +: PAYLOAD_W] = head_e[b].payload;
      occupancy[b*CNT_W +: CNT_W]           = cnt_q[b];
    end
  end

  assign int_stall = ext_stall | (|(enq_valid & full));

endmodule
